// File: rtl/cga_bus_regs.sv
// cga_bus_regs
//   ISA front-end and register bank for a CGA/Tandy video adapter.
//   - Synchronises the ISA strobes and the CRTC status inputs.
//   - Decodes the I/O window: CRTC (base+0..7), mode control (base+8),
//     colour select (base+9), status / gate-array index (base+A) and
//     gate-array data (base+E).
//   - Holds the Tandy gate-array file: border colour, mode-2 and a palette
//     with auto-incrementing index.
//   - Generates VRAM wait states and the blink timebase.
//
// Ports
//   clk, rst_l              clock, asynchronous active-low reset
//   bus_a, bus_d            ISA address / write data
//   bus_ior_l, bus_iow_l    ISA I/O strobes (asynchronous, active low)
//   bus_memr_l, bus_memw_l  ISA memory strobes (asynchronous, active low)
//   bus_aen                 DMA cycle, blocks all I/O decode
//   bus_mem_cs              framebuffer window hit
//   bus_out, bus_dir        read data and drive enable
//   bus_rdy                 ISA ready (low while inserting wait states)
//   crtc_rdata              CRTC register read data
//   vsync_l, display_enable CRTC status (asynchronous)
//   crtc_cs, crtc_wr, crtc_rd  CRTC select and one-clk access pulses
//   control_reg, color_reg  mode control / colour select registers
//   video_enabled           display enable from the mode register
//   border_col, mode2_reg   gate-array registers 0x02 / 0x03
//   pal_rd_idx, pal_rd_data palette lookup for the pixel pipeline
//   blink_freeze, blink     blink hold input / blink square wave
module cga_bus_regs #(
    parameter logic [15:0] IO_BASE_ADDR       = 16'h3D0,
    parameter int          PAL_ENTRIES        = 16,
    parameter int          WAIT_CYCLES        = 4,
    parameter logic [23:0] BLINK_MAX          = 24'd0,
    parameter bit          NO_DISPLAY_DISABLE = 1'b0
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic [14:0] bus_a,
    input  logic        bus_ior_l,
    input  logic        bus_iow_l,
    input  logic        bus_memr_l,
    input  logic        bus_memw_l,
    input  logic        bus_aen,
    input  logic        bus_mem_cs,
    input  logic [7:0]  bus_d,
    output logic [7:0]  bus_out,
    output logic        bus_dir,
    output logic        bus_rdy,
    input  logic [7:0]  crtc_rdata,
    input  logic        vsync_l,
    input  logic        display_enable,
    output logic        crtc_cs,
    output logic        crtc_wr,
    output logic        crtc_rd,
    output logic [7:0]  control_reg,
    output logic [7:0]  color_reg,
    output logic        video_enabled,
    output logic [3:0]  border_col,
    output logic [3:0]  mode2_reg,
    input  logic [3:0]  pal_rd_idx,
    output logic [3:0]  pal_rd_data,
    input  logic        blink_freeze,
    output logic        blink
);

    localparam logic [14:0] BASE       = IO_BASE_ADDR[14:0];
    localparam logic [14:0] ADDR_CTL   = BASE + 15'd8;
    localparam logic [14:0] ADDR_COL   = BASE + 15'd9;
    localparam logic [14:0] ADDR_STAT  = BASE + 15'd10;
    localparam logic [14:0] ADDR_GADAT = BASE + 15'd14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } ws_state_t;

    // ------------------------------------------------------------------
    // Input synchronisers. Bit map: 0 ior, 1 iow, 2 memr, 3 memw,
    // 4 vsync_l, 5 display_enable. All reset to 1 so that releasing reset
    // with idle strobes never looks like a falling edge.
    // ------------------------------------------------------------------
    logic [5:0] async_in;
    logic [5:0] sync1_reg;
    logic [5:0] sync2_reg;
    logic       ior_prev_reg;
    logic       iow_prev_reg;

    assign async_in = {display_enable, vsync_l, bus_memw_l, bus_memr_l,
                       bus_iow_l, bus_ior_l};

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            sync1_reg    <= '1;
            sync2_reg    <= '1;
            ior_prev_reg <= 1'b1;
            iow_prev_reg <= 1'b1;
        end else begin
            sync1_reg    <= async_in;
            sync2_reg    <= sync1_reg;
            ior_prev_reg <= sync2_reg[0];
            iow_prev_reg <= sync2_reg[1];
        end
    end

    logic ior_s, iow_s, memr_s, memw_s, vsync_s, de_s;
    logic ior_fall, iow_fall;

    assign ior_s   = sync2_reg[0];
    assign iow_s   = sync2_reg[1];
    assign memr_s  = sync2_reg[2];
    assign memw_s  = sync2_reg[3];
    assign vsync_s = sync2_reg[4];
    assign de_s    = sync2_reg[5];

    // One-clock strobe edges: a long strobe still yields a single commit.
    assign ior_fall = ior_prev_reg & ~ior_s;
    assign iow_fall = iow_prev_reg & ~iow_s;

    // ------------------------------------------------------------------
    // Address decode (raw bus_a, blocked during DMA cycles)
    // ------------------------------------------------------------------
    logic sel_ctl, sel_col, sel_stat, sel_ga;

    assign crtc_cs  = ~bus_aen && (bus_a[14:3] == BASE[14:3]);
    assign sel_ctl  = ~bus_aen && (bus_a == ADDR_CTL);
    assign sel_col  = ~bus_aen && (bus_a == ADDR_COL);
    assign sel_stat = ~bus_aen && (bus_a == ADDR_STAT);
    assign sel_ga   = ~bus_aen && (bus_a == ADDR_GADAT);

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [4:0] ga_index_reg;
    logic       pal_hit;
    logic       pal_last;
    logic       pal_we;

    // Palette lives at gate-array indices 0x10 .. 0x10+PAL_ENTRIES-1.
    assign pal_hit  = ga_index_reg[4] &&
                      ({1'b0, ga_index_reg[3:0]} < 5'(PAL_ENTRIES));
    assign pal_last = (ga_index_reg[3:0] == 4'(PAL_ENTRIES - 1));
    assign pal_we   = iow_fall && sel_ga && pal_hit;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            control_reg  <= 8'h29;
            color_reg    <= 8'h00;
            border_col   <= 4'h0;
            mode2_reg    <= 4'h0;
            ga_index_reg <= 5'h00;
            crtc_wr      <= 1'b0;
            crtc_rd      <= 1'b0;
        end else begin
            crtc_wr <= iow_fall && crtc_cs;
            crtc_rd <= ior_fall && crtc_cs && bus_a[0];

            // Reading the status port resets the Tandy index flip-flop.
            if (ior_fall && sel_stat) begin
                ga_index_reg <= 5'h00;
            end

            if (iow_fall) begin
                if (sel_ctl) begin
                    control_reg <= bus_d;
                end
                if (sel_col) begin
                    color_reg <= bus_d;
                end
                if (sel_stat) begin
                    ga_index_reg <= bus_d[4:0];
                end
                if (sel_ga) begin
                    if (ga_index_reg == 5'h02) begin
                        border_col <= bus_d[3:0];
                    end else if (ga_index_reg == 5'h03) begin
                        mode2_reg <= bus_d[3:0];
                    end else if (pal_hit) begin
                        // Auto-increment through the palette, wrapping to
                        // the first entry after the last one.
                        ga_index_reg <= pal_last ? 5'h10 : ga_index_reg + 5'd1;
                    end
                end
            end
        end
    end

    // Palette entries are reset to identity, so they are kept in flops.
    logic [3:0] pal [PAL_ENTRIES];

    for (genvar gi = 0; gi < PAL_ENTRIES; gi++) begin : g_pal
        logic [3:0] entry_reg;

        always_ff @(posedge clk or negedge rst_l) begin
            if (!rst_l) begin
                entry_reg <= 4'(gi);
            end else if (pal_we && (ga_index_reg[3:0] == 4'(gi))) begin
                entry_reg <= bus_d[3:0];
            end
        end

        assign pal[gi] = entry_reg;
    end

    // Out-of-range lookups pass the index straight through.
    always_comb begin
        pal_rd_data = pal_rd_idx;
        for (int i = 0; i < PAL_ENTRIES; i++) begin
            if (pal_rd_idx == 4'(i)) begin
                pal_rd_data = pal[i];
            end
        end
    end

    assign video_enabled = NO_DISPLAY_DISABLE ? 1'b1 : control_reg[3];

    // ------------------------------------------------------------------
    // Read path (combinational on the raw read strobe)
    // ------------------------------------------------------------------
    always_comb begin
        bus_out = 8'h00;
        if (sel_stat && !bus_ior_l) begin
            bus_out = {4'hF, vsync_s, 2'b10, ~de_s};
        end else if (crtc_cs && bus_a[0] && !bus_ior_l) begin
            bus_out = crtc_rdata;
        end
    end

    assign bus_dir = (crtc_cs | sel_stat) & ~bus_ior_l;

    // ------------------------------------------------------------------
    // VRAM wait-state generator
    // ------------------------------------------------------------------
    logic mem_active;
    assign mem_active = ~memr_s | ~memw_s;

    if (WAIT_CYCLES == 0) begin : g_no_wait
        logic unused_mem;
        assign unused_mem = ^{bus_mem_cs, mem_active};
        assign bus_rdy    = 1'b1;
    end else begin : g_wait
        localparam int CNT_W = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
        localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

        ws_state_t        state_reg;
        logic [CNT_W-1:0] cnt_reg;
        logic             rdy_reg;

        always_ff @(posedge clk or negedge rst_l) begin
            if (!rst_l) begin
                state_reg <= ST_IDLE;
                cnt_reg   <= '0;
                rdy_reg   <= 1'b1;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (bus_mem_cs && mem_active) begin
                            state_reg <= ST_WAIT;
                            cnt_reg   <= CNT_LOAD;
                            rdy_reg   <= 1'b0;
                        end
                    end
                    ST_WAIT: begin
                        // An aborted cycle must not leave the bus stalled.
                        if (!mem_active) begin
                            state_reg <= ST_IDLE;
                            rdy_reg   <= 1'b1;
                        end else if (cnt_reg == '0) begin
                            state_reg <= ST_DONE;
                            rdy_reg   <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg - 1'b1;
                        end
                    end
                    ST_DONE: begin
                        if (!mem_active) begin
                            state_reg <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                        rdy_reg   <= 1'b1;
                    end
                endcase
            end
        end

        assign bus_rdy = rdy_reg;
    end

    // ------------------------------------------------------------------
    // Blink timebase
    // ------------------------------------------------------------------
    logic [23:0] blink_cnt_reg;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            blink_cnt_reg <= 24'd0;
            blink         <= 1'b0;
        end else if (!blink_freeze) begin
            if (blink_cnt_reg == BLINK_MAX) begin
                blink_cnt_reg <= 24'd0;
                blink         <= ~blink;
            end else begin
                blink_cnt_reg <= blink_cnt_reg + 24'd1;
            end
        end
    end

endmodule

// File: tb/tb_cga_bus_regs.sv
// Testbench for cga_bus_regs: a table of bus transactions with expected
// register values, followed by hand-written sequences for commit timing,
// CRTC pulses, wait states, reset during an access and the blink timebase.
// Expected values go through a scoreboard queue.
module tb_cga_bus_regs;

    logic        clk;
    logic        rst_l;
    logic [14:0] bus_a;
    logic        bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l;
    logic        bus_aen, bus_mem_cs;
    logic [7:0]  bus_d;
    logic [7:0]  bus_out;
    logic        bus_dir, bus_rdy;
    logic [7:0]  crtc_rdata;
    logic        vsync_l, display_enable;
    logic        crtc_cs, crtc_wr, crtc_rd;
    logic [7:0]  control_reg, color_reg;
    logic        video_enabled;
    logic [3:0]  border_col, mode2_reg;
    logic [3:0]  pal_rd_idx, pal_rd_data;
    logic        blink_freeze, blink;

    cga_bus_regs #(
        .IO_BASE_ADDR      (16'h3D0),
        .PAL_ENTRIES       (16),
        .WAIT_CYCLES       (4),
        .BLINK_MAX         (24'd3),
        .NO_DISPLAY_DISABLE(1'b0)
    ) dut (
        .clk           (clk),
        .rst_l         (rst_l),
        .bus_a         (bus_a),
        .bus_ior_l     (bus_ior_l),
        .bus_iow_l     (bus_iow_l),
        .bus_memr_l    (bus_memr_l),
        .bus_memw_l    (bus_memw_l),
        .bus_aen       (bus_aen),
        .bus_mem_cs    (bus_mem_cs),
        .bus_d         (bus_d),
        .bus_out       (bus_out),
        .bus_dir       (bus_dir),
        .bus_rdy       (bus_rdy),
        .crtc_rdata    (crtc_rdata),
        .vsync_l       (vsync_l),
        .display_enable(display_enable),
        .crtc_cs       (crtc_cs),
        .crtc_wr       (crtc_wr),
        .crtc_rd       (crtc_rd),
        .control_reg   (control_reg),
        .color_reg     (color_reg),
        .video_enabled (video_enabled),
        .border_col    (border_col),
        .mode2_reg     (mode2_reg),
        .pal_rd_idx    (pal_rd_idx),
        .pal_rd_data   (pal_rd_data),
        .blink_freeze  (blink_freeze),
        .blink         (blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        string      name;
        logic [7:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  total = 0;
    int  bad   = 0;

    task automatic push(input string name, input logic [7:0] exp);
        sb_t e;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic check_pop(input logic [7:0] act);
        sb_t e;
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty got=%h", act);
        end else begin
            e = sb_q.pop_front();
            if (act !== e.exp) begin
                bad++;
                $display("FAIL %s got=%h exp=%h", e.name, act, e.exp);
            end
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        push(name, exp);
        check_pop(act);
    endtask

    // ------------------------------------------------------------------
    // Monitors: CRTC pulse counters and the reference blink time count
    // ------------------------------------------------------------------
    int wr_pulses = 0;
    int rd_pulses = 0;
    int blink_active = 0;

    always @(negedge clk) begin
        if (crtc_wr) wr_pulses++;
        if (crtc_rd) rd_pulses++;
    end

    // Number of unfrozen clocks since reset; blink must equal bit
    // floor(count / (BLINK_MAX+1)) mod 2.
    always @(posedge clk or negedge rst_l) begin
        if (!rst_l) blink_active <= 0;
        else if (!blink_freeze) blink_active <= blink_active + 1;
    end

    // ------------------------------------------------------------------
    // Bus helpers
    // ------------------------------------------------------------------
    logic [7:0] rd_out;
    logic       rd_dir;

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic io_xfer(input logic wr, input logic [14:0] a, input logic [7:0] d,
                           input logic aen, input int hold);
        @(negedge clk);
        bus_a   = a;
        bus_d   = d;
        bus_aen = aen;
        if (wr) bus_iow_l = 1'b0;
        else    bus_ior_l = 1'b0;
        repeat (hold) @(negedge clk);
        rd_out    = bus_out;
        rd_dir    = bus_dir;
        bus_iow_l = 1'b1;
        bus_ior_l = 1'b1;
        repeat (3) @(negedge clk);
        bus_aen = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    localparam int K_WR = 0, K_RD = 1, K_NONE = 2;
    localparam int OBS_CTL = 0, OBS_COL = 1, OBS_BORDER = 2, OBS_MODE2 = 3,
                   OBS_PAL = 4, OBS_BUS = 5, OBS_VID = 6;

    typedef struct {
        string       name;
        int          kind;
        logic [14:0] a;
        logic [7:0]  d;
        logic        aen;
        int          hold;
        logic        vs;
        logic        de;
        int          obs;
        logic [3:0]  pidx;
        logic [7:0]  exp;
        logic        exp_dir;
    } vec_t;

    vec_t vecs[$];

    task automatic addv(input string n, input int kind, input logic [14:0] a,
                        input logic [7:0] d, input logic aen, input int hold,
                        input logic vs, input logic de, input int obs,
                        input logic [3:0] pidx, input logic [7:0] exp,
                        input logic exp_dir);
        vec_t v;
        v.name = n; v.kind = kind; v.a = a; v.d = d; v.aen = aen; v.hold = hold;
        v.vs = vs; v.de = de; v.obs = obs; v.pidx = pidx; v.exp = exp;
        v.exp_dir = exp_dir;
        vecs.push_back(v);
    endtask

    function automatic logic [7:0] observe(input int obs);
        case (obs)
            OBS_CTL:    return control_reg;
            OBS_COL:    return color_reg;
            OBS_BORDER: return {4'h0, border_col};
            OBS_MODE2:  return {4'h0, mode2_reg};
            OBS_PAL:    return {4'h0, pal_rd_data};
            OBS_BUS:    return rd_out;
            default:    return {7'h00, video_enabled};
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int w0, r0;
        logic exp_blink;

        rst_l = 1'b1;
        bus_a = '0; bus_d = '0;
        bus_ior_l = 1'b1; bus_iow_l = 1'b1; bus_memr_l = 1'b1; bus_memw_l = 1'b1;
        bus_aen = 1'b0; bus_mem_cs = 1'b0;
        crtc_rdata = 8'hA5;
        vsync_l = 1'b0; display_enable = 1'b1;
        pal_rd_idx = 4'd5;
        blink_freeze = 1'b0;
        rd_out = '0; rd_dir = 1'b0;

        #1 rst_l = 1'b0;
        idle(3);
        chk("rst_control",  control_reg, 8'h29);
        chk("rst_color",    color_reg, 8'h00);
        chk("rst_border",   {4'h0, border_col}, 8'h00);
        chk("rst_mode2",    {4'h0, mode2_reg}, 8'h00);
        chk("rst_pal5",     {4'h0, pal_rd_data}, 8'h05);
        chk("rst_rdy",      {7'h0, bus_rdy}, 8'h01);
        chk("rst_blink",    {7'h0, blink}, 8'h00);
        chk("rst_crtc_wr",  {7'h0, crtc_wr}, 8'h00);
        chk("rst_crtc_rd",  {7'h0, crtc_rd}, 8'h00);
        chk("rst_vid_en",   {7'h0, video_enabled}, 8'h01);
        rst_l = 1'b1;
        idle(2);

        //    name         kind    addr      data  aen  hold vs    de    obs         pidx exp    dir
        addv("stat_rd",    K_RD,   15'h3DA, 8'h00, 0,   4,   1'b0, 1'b1, OBS_BUS,    0,  8'hF4, 1'b1);
        addv("ctl_long",   K_WR,   15'h3D8, 8'h1A, 0,   20,  1'b0, 1'b1, OBS_CTL,    0,  8'h1A, 1'b0);
        addv("vid_en1",    K_NONE, 15'h000, 8'h00, 0,   0,   1'b0, 1'b1, OBS_VID,    0,  8'h01, 1'b0);
        addv("ctl_aen",    K_WR,   15'h3D8, 8'h55, 1,   4,   1'b0, 1'b1, OBS_CTL,    0,  8'h1A, 1'b0);
        addv("col",        K_WR,   15'h3D9, 8'h3C, 0,   4,   1'b0, 1'b1, OBS_COL,    0,  8'h3C, 1'b0);
        addv("idx1e",      K_WR,   15'h3DA, 8'h1E, 0,   4,   1'b0, 1'b1, OBS_PAL,    14, 8'h0E, 1'b0);
        addv("pal14",      K_WR,   15'h3DE, 8'h07, 0,   4,   1'b0, 1'b1, OBS_PAL,    14, 8'h07, 1'b0);
        addv("pal15",      K_WR,   15'h3DE, 8'h09, 0,   4,   1'b0, 1'b1, OBS_PAL,    15, 8'h09, 1'b0);
        addv("pal0_wrap",  K_WR,   15'h3DE, 8'h03, 0,   4,   1'b0, 1'b1, OBS_PAL,    0,  8'h03, 1'b0);
        addv("pal1",       K_WR,   15'h3DE, 8'h0A, 0,   4,   1'b0, 1'b1, OBS_PAL,    1,  8'h0A, 1'b0);
        addv("stat_clr",   K_RD,   15'h3DA, 8'h00, 0,   4,   1'b1, 1'b0, OBS_BUS,    0,  8'hFD, 1'b1);
        addv("idx0_ign",   K_WR,   15'h3DE, 8'h0B, 0,   4,   1'b0, 1'b1, OBS_PAL,    2,  8'h02, 1'b0);
        addv("idx2",       K_WR,   15'h3DA, 8'h02, 0,   4,   1'b0, 1'b1, OBS_BORDER, 0,  8'h00, 1'b0);
        addv("border",     K_WR,   15'h3DE, 8'h0C, 0,   4,   1'b0, 1'b1, OBS_BORDER, 0,  8'h0C, 1'b0);
        addv("border_again",K_WR,  15'h3DE, 8'h05, 0,   4,   1'b0, 1'b1, OBS_BORDER, 0,  8'h05, 1'b0);
        addv("idx3",       K_WR,   15'h3DA, 8'h03, 0,   4,   1'b0, 1'b1, OBS_MODE2,  0,  8'h00, 1'b0);
        addv("mode2",      K_WR,   15'h3DE, 8'h06, 0,   4,   1'b0, 1'b1, OBS_MODE2,  0,  8'h06, 1'b0);
        addv("idx7",       K_WR,   15'h3DA, 8'h07, 0,   4,   1'b0, 1'b1, OBS_MODE2,  0,  8'h06, 1'b0);
        addv("ga7_mode2",  K_WR,   15'h3DE, 8'h0F, 0,   4,   1'b0, 1'b1, OBS_MODE2,  0,  8'h06, 1'b0);
        addv("ga7_border", K_NONE, 15'h000, 8'h00, 0,   0,   1'b0, 1'b1, OBS_BORDER, 0,  8'h05, 1'b0);
        addv("ga7_pal",    K_NONE, 15'h000, 8'h00, 0,   0,   1'b0, 1'b1, OBS_PAL,    7,  8'h07, 1'b0);
        addv("idx_mask",   K_WR,   15'h3DA, 8'hF0, 0,   4,   1'b0, 1'b1, OBS_PAL,    0,  8'h03, 1'b0);
        addv("pal0",       K_WR,   15'h3DE, 8'h08, 0,   4,   1'b0, 1'b1, OBS_PAL,    0,  8'h08, 1'b0);
        addv("crtc_rd1",   K_RD,   15'h3D1, 8'h00, 0,   4,   1'b0, 1'b1, OBS_BUS,    0,  8'hA5, 1'b1);
        addv("crtc_rd0",   K_RD,   15'h3D0, 8'h00, 0,   4,   1'b0, 1'b1, OBS_BUS,    0,  8'h00, 1'b1);
        addv("unmapped",   K_RD,   15'h3DC, 8'h00, 0,   4,   1'b0, 1'b1, OBS_BUS,    0,  8'h00, 1'b0);
        addv("stat_aen",   K_RD,   15'h3DA, 8'h00, 1,   4,   1'b0, 1'b1, OBS_BUS,    0,  8'h00, 1'b0);
        addv("vid_off",    K_WR,   15'h3D8, 8'h21, 0,   4,   1'b0, 1'b1, OBS_VID,    0,  8'h00, 1'b0);
        addv("mda_miss",   K_WR,   15'h3B8, 8'h77, 0,   4,   1'b0, 1'b1, OBS_CTL,    0,  8'h21, 1'b0);

        foreach (vecs[i]) begin
            vsync_l        = vecs[i].vs;
            display_enable = vecs[i].de;
            pal_rd_idx     = vecs[i].pidx;
            idle(3);
            push(vecs[i].name, vecs[i].exp);
            if (vecs[i].kind == K_RD) push({vecs[i].name, "_dir"}, {7'h0, vecs[i].exp_dir});
            if (vecs[i].kind != K_NONE)
                io_xfer(vecs[i].kind == K_WR, vecs[i].a, vecs[i].d, vecs[i].aen, vecs[i].hold);
            check_pop(observe(vecs[i].obs));
            if (vecs[i].kind == K_RD) check_pop({7'h0, rd_dir});
        end

        // Commit latency: two synchroniser stages, commit on the third edge.
        @(negedge clk);
        bus_a = 15'h3D9; bus_d = 8'h5A; bus_iow_l = 1'b0;
        push("col_edge2", 8'h3C);
        push("col_edge3", 8'h5A);
        idle(2);
        check_pop(color_reg);
        idle(1);
        check_pop(color_reg);
        idle(2);
        bus_iow_l = 1'b1;
        idle(4);

        // CRTC access pulses
        w0 = wr_pulses;
        io_xfer(1'b1, 15'h3D4, 8'h0E, 1'b0, 10);
        chk("crtc_wr_once", 8'(wr_pulses - w0), 8'd1);
        r0 = rd_pulses;
        io_xfer(1'b0, 15'h3D5, 8'h00, 1'b0, 6);
        chk("crtc_rd_odd", 8'(rd_pulses - r0), 8'd1);
        r0 = rd_pulses;
        io_xfer(1'b0, 15'h3D4, 8'h00, 1'b0, 6);
        chk("crtc_rd_even", 8'(rd_pulses - r0), 8'd0);
        w0 = wr_pulses;
        io_xfer(1'b1, 15'h3D8, 8'h21, 1'b0, 6);
        chk("crtc_wr_ctl", 8'(wr_pulses - w0), 8'd0);

        // Full wait-state access: 2 sync clocks, then 4 clocks not ready.
        @(negedge clk);
        bus_mem_cs = 1'b1; bus_memr_l = 1'b0;
        push("ws_e1", 8'd1); push("ws_e2", 8'd1); push("ws_e3", 8'd0); push("ws_e4", 8'd0);
        push("ws_e5", 8'd0); push("ws_e6", 8'd0); push("ws_e7", 8'd1); push("ws_e8", 8'd1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_pop({7'h0, bus_rdy});
        end
        idle(3);
        chk("ws_done_hold", {7'h0, bus_rdy}, 8'd1);
        bus_memr_l = 1'b1;
        idle(4);
        chk("ws_idle", {7'h0, bus_rdy}, 8'd1);
        bus_mem_cs = 1'b0;
        idle(2);

        // Strobe released early in WAIT.
        @(negedge clk);
        bus_mem_cs = 1'b1; bus_memr_l = 1'b0;
        push("early_e3", 8'd0); push("early_e4", 8'd0);
        push("early_e5", 8'd0); push("early_e6", 8'd1);
        idle(3);
        check_pop({7'h0, bus_rdy});
        bus_memr_l = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_pop({7'h0, bus_rdy});
        end
        idle(3);

        // A memory write strobe also inserts wait states.
        @(negedge clk);
        bus_memw_l = 1'b0;
        idle(3);
        chk("memw_wait", {7'h0, bus_rdy}, 8'd0);
        bus_memw_l = 1'b1;
        idle(6);
        chk("memw_release", {7'h0, bus_rdy}, 8'd1);

        // Reset in the middle of WAIT acts immediately.
        @(negedge clk);
        bus_memr_l = 1'b0;
        idle(4);
        chk("rst_pre_wait", {7'h0, bus_rdy}, 8'd0);
        #2 rst_l = 1'b0;
        #1;
        chk("rst_mid_rdy", {7'h0, bus_rdy}, 8'd1);
        chk("rst_mid_ctl", control_reg, 8'h29);
        chk("rst_mid_border", {4'h0, border_col}, 8'h00);
        bus_memr_l = 1'b1; bus_mem_cs = 1'b0;
        @(negedge clk);
        rst_l = 1'b1;
        idle(3);
        chk("rst_post_rdy", {7'h0, bus_rdy}, 8'd1);
        chk("rst_post_ctl", control_reg, 8'h29);

        // Blink timebase with a freeze window in the middle.
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            exp_blink = 1'((blink_active / 4) % 2);
            chk("blink", {7'h0, blink}, {7'h0, exp_blink});
            blink_freeze = (k >= 10 && k < 17);
        end

        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
